// File: rtl/cache_pkg.sv
// Shared cache/memory definitions: line geometry, responder state encoding, error fill pattern.
package cache_pkg;

  localparam int BLOCK_SIZE  = 64;
  localparam int BLOCK_WORDS = BLOCK_SIZE / 4;
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
  localparam int WORD_BITS   = 32;

  localparam logic [WORD_BITS-1:0] ERR_PATTERN = 32'hDEAD_DEAD;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD_BURST,
    WR_BURST,
    DONE
  } resp_state_t;

endpackage

// File: rtl/cache_mem_array.sv
// Backing word store for the memory responder: single port, asynchronous read, synchronous write.
module cache_mem_array
  import cache_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [WORD_BITS-1:0] wdata,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for L1 line fills and write-backs with a fixed access latency.
// Optional CACHE_MEM_RANGE_CHECK_EN: out-of-range requests raise err instead of wrapping.
//
// state    | meaning
// IDLE     | ready for a new burst request
// WAIT     | latency down-counter running
// RD_BURST | presenting fill beats on rdata
// WR_BURST | accepting write-back beats
// DONE     | one-cycle wr_done pulse
module cache_mem_responder
  import cache_pkg::*;
#(
  parameter int BLOCK_SIZE = 64,
  parameter int MEM_WORDS  = 4096,
  parameter int LATENCY    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_last,
  output logic        wr_done,
  output logic        busy,
  output logic        err
);

  localparam int BEATS  = BLOCK_SIZE / 4;
  localparam int BB     = $clog2(BEATS);
  localparam int AW     = $clog2(MEM_WORDS);
  localparam int LINE_W = AW - BB;
  localparam int LW     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [BB-1:0] LAST_BEAT = BB'(BEATS - 1);
  localparam logic [LW-1:0] LAT_LOAD  = LW'(LATENCY);

  resp_state_t          state;
  logic [LINE_W-1:0]    line;
  logic [LINE_W-1:0]    req_line;
  logic [BB-1:0]        beat;
  logic [BB-1:0]        beat_nxt;
  logic [LW-1:0]        lat_cnt;
  logic                 is_write;
  logic                 oor;
  logic                 req_oor;
  logic [AW-1:0]        mem_addr;
  logic [WORD_BITS-1:0] mem_rdata;
  logic [WORD_BITS-1:0] rd_word;
  logic                 mem_we;
  logic                 unused_addr_bits;

  assign req_line         = req_addr[AW+1:BB+2];
  assign beat_nxt         = beat + 1'b1;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[BB+1:0]};

`ifdef CACHE_MEM_RANGE_CHECK_EN
  assign req_oor = |req_addr[31:AW+2];
  assign err     = oor;
`else
  assign req_oor = 1'b0;
  assign err     = 1'b0;
`endif

  // Look-ahead read address so rdata can be registered on the same edge that moves the beat.
  always_comb begin
    mem_addr = {line, beat};
    case (state)
      IDLE:     mem_addr = {req_line, {BB{1'b0}}};
      WAIT:     mem_addr = {line, {BB{1'b0}}};
      RD_BURST: mem_addr = {line, beat_nxt};
      default:  mem_addr = {line, beat};
    endcase
  end

  assign rd_word = (((state == IDLE) ? req_oor : oor) == 1'b1) ? ERR_PATTERN : mem_rdata;
  assign mem_we  = (state == WR_BURST) && wdata_valid && !oor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      wr_done     <= 1'b0;
      busy        <= 1'b0;
      rdata       <= '0;
      beat        <= '0;
      lat_cnt     <= '0;
      line        <= '0;
      is_write    <= 1'b0;
      oor         <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            line      <= req_line;
            is_write  <= req_write;
            oor       <= req_oor;
            lat_cnt   <= LAT_LOAD;
            beat      <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (LATENCY != 0) begin
              state <= WAIT;
            end else if (req_write) begin
              state       <= WR_BURST;
              wdata_ready <= 1'b1;
            end else begin
              state       <= RD_BURST;
              rdata_valid <= 1'b1;
              rdata_last  <= 1'b0;
              rdata       <= rd_word;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            if (is_write) begin
              state       <= WR_BURST;
              wdata_ready <= 1'b1;
            end else begin
              state       <= RD_BURST;
              rdata_valid <= 1'b1;
              rdata_last  <= 1'b0;
              rdata       <= rd_word;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RD_BURST: begin
          if (rdata_ready) begin
            if (beat == LAST_BEAT) begin
              state       <= IDLE;
              rdata_valid <= 1'b0;
              rdata_last  <= 1'b0;
              beat        <= '0;
              req_ready   <= 1'b1;
              busy        <= 1'b0;
            end else begin
              beat       <= beat_nxt;
              rdata      <= rd_word;
              rdata_last <= (beat_nxt == LAST_BEAT);
            end
          end
        end
        WR_BURST: begin
          if (wdata_valid) begin
            if (beat == LAST_BEAT) begin
              state       <= DONE;
              wdata_ready <= 1'b0;
              wr_done     <= 1'b1;
              beat        <= '0;
            end else begin
              beat <= beat_nxt;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  cache_mem_array #(
    .MEM_WORDS(MEM_WORDS),
    .AW       (AW)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(wdata),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder against a word-array model of the backing store.
module tb_cache_mem_responder;

  localparam int MEM_WORDS = 4096;
  localparam int LATENCY   = 8;
  localparam int BEATS     = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] wdata = '0;
  logic        rdata_valid;
  logic        rdata_ready = 1'b0;
  logic [31:0] rdata;
  logic        rdata_last;
  logic        wr_done;
  logic        busy;
  logic        err;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem_m [MEM_WORDS];

  cache_mem_responder #(
    .BLOCK_SIZE(64),
    .MEM_WORDS (MEM_WORDS),
    .LATENCY   (LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready),
    .rdata      (rdata),
    .rdata_last (rdata_last),
    .wr_done    (wr_done),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Word index of beat b of the line containing byte address addr (wraps modulo store depth).
  function automatic int widx(input logic [31:0] addr, input int b);
    logic [31:0] w;
    w = ((addr >> 2) & 32'(MEM_WORDS - 1) & ~32'(BEATS - 1)) + 32'(b);
    return int'(w);
  endfunction

  function automatic logic exp_oor(input logic [31:0] addr);
`ifdef CACHE_MEM_RANGE_CHECK_EN
    return (addr >> 2) >= 32'(MEM_WORDS);
`else
    return addr[0] & 1'b0;
`endif
  endfunction

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic hold, output int acc);
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_wait: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    @(negedge clk);
    acc = cyc;
    req_valid = hold;
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || err !== exp_oor(addr)) begin
      errors++;
      $display("FAIL accept: busy=%b req_ready=%b err=%b required 1 0 %b", busy, req_ready, err, exp_oor(addr));
    end
  endtask

  task automatic write_data(input logic [31:0] addr, input logic [31:0] d [BEATS], input int gap_pct);
    int b = 0;
    int n = 0;
    logic hs;
    logic o;
    o = exp_oor(addr);
    while (b < BEATS && n < 300) begin
      wdata       = d[b];
      wdata_valid = ($urandom_range(99) >= 32'(gap_pct));
      hs = wdata_valid && (wdata_ready === 1'b1);
      @(negedge clk);
      n++;
      if (hs) begin
        if (!o) mem_m[widx(addr, b)] = d[b];
        b++;
      end
    end
    wdata_valid = 1'b0;
    checks++;
    if (b != BEATS) begin
      errors++;
      $display("FAIL wr_beats: accepted=%0d required %0d", b, BEATS);
    end
    checks++;
    if (wr_done !== 1'b1) begin
      errors++;
      $display("FAIL wr_done_pulse: wr_done=%b required 1", wr_done);
    end
    @(negedge clk);
    checks++;
    if (wr_done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_done_end: wr_done=%b req_ready=%b busy=%b required 0 1 0", wr_done, req_ready, busy);
    end
  endtask

  task automatic read_data(input logic [31:0] addr, input int mode, input int acc, input logic hold);
    int b = 0;
    int n = 0;
    int lat = -1;
    int rr_bad = 0;
    logic stalled = 1'b0;
    logic [31:0] held = '0;
    logic [31:0] e;
    logic o;
    o = exp_oor(addr);
    while (b < BEATS && n < 300) begin
      if (hold && req_ready !== 1'b0) rr_bad++;
      if (rdata_valid === 1'b1) begin
        if (lat < 0) lat = cyc - acc;
        if (stalled) begin
          checks++;
          if (rdata !== held) begin
            errors++;
            $display("FAIL stall_hold: rdata=%h required %h", rdata, held);
          end
        end
        case (mode)
          0:       rdata_ready = 1'b1;
          1:       rdata_ready = !rdata_ready;
          default: rdata_ready = 1'($urandom_range(1));
        endcase
        if (rdata_ready) begin
          e = o ? 32'hDEAD_DEAD : mem_m[widx(addr, b)];
          checks++;
          if (rdata !== e || rdata_last !== (b == BEATS - 1) || err !== o) begin
            errors++;
            $display("FAIL rd_beat%0d: rdata=%h last=%b err=%b required %h %b %b",
                     b, rdata, rdata_last, err, e, (b == BEATS - 1), o);
          end
          b++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = rdata;
        end
      end
      @(negedge clk);
      n++;
    end
    rdata_ready = 1'b0;
    checks++;
    if (b != BEATS) begin
      errors++;
      $display("FAIL rd_beats: handshakes=%0d required %0d", b, BEATS);
    end
    checks++;
    if (lat != LATENCY + 1) begin
      errors++;
      $display("FAIL rd_latency: first valid %0d cycles after accept, required %0d", lat, LATENCY + 1);
    end
    checks++;
    if (rdata_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_end: rdata_valid=%b req_ready=%b required 0 1", rdata_valid, req_ready);
    end
    if (hold) begin
      checks++;
      if (rr_bad != 0) begin
        errors++;
        $display("FAIL req_ready_busy: req_ready high in %0d busy cycles, required 0", rr_bad);
      end
    end
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [31:0] d [BEATS], input int gap_pct);
    int acc;
    do_req(1'b1, addr, 1'b0, acc);
    write_data(addr, d, gap_pct);
  endtask

  task automatic read_burst(input logic [31:0] addr, input int mode);
    int acc;
    do_req(1'b0, addr, 1'b0, acc);
    read_data(addr, mode, acc, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, wdata_ready, rdata_valid, rdata_last, wr_done, busy, err} !== 7'b1000000 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: rdy/wrdy/rv/last/done/busy/err=%b rdata=%h required 1000000 0",
               {req_ready, wdata_ready, rdata_valid, rdata_last, wr_done, busy, err}, rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: req_ready=%b busy=%b required 1 0", req_ready, busy);
    end
  endtask

  task automatic test_fill_latency();
    logic [31:0] d [BEATS];
    for (int i = 0; i < BEATS; i++) d[i] = 32'h40 + 32'(i);
    write_burst(32'h0000_0100, d, 0);
    read_burst(32'h0000_0100, 0);
  endtask

  task automatic test_write_then_read();
    logic [31:0] d [BEATS];
    for (int i = 0; i < BEATS; i++) d[i] = 32'hCAFE_0000 + 32'(i);
    write_burst(32'h0000_0200, d, 30);
    read_burst(32'h0000_0200, 0);
  endtask

  task automatic test_read_stall();
    rdata_ready = 1'b0;
    read_burst(32'h0000_0200 + 32'h3C, 1);
  endtask

  task automatic test_back_to_back();
    int acc;
    int acc2;
    do_req(1'b0, 32'h0000_0100, 1'b1, acc);
    req_write = 1'b0;
    req_addr  = 32'h0000_0200;
    read_data(32'h0000_0100, 0, acc, 1'b1);
    @(negedge clk);
    acc2 = cyc;
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL held_req_accept: busy=%b req_ready=%b required 1 0", busy, req_ready);
    end
    read_data(32'h0000_0200, 2, acc2, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] addr = 32'h0000_0800;
    logic [31:0] d [BEATS];
    int acc;
    int b = 0;
    int n = 0;
    int wd = 0;
    logic hs;
    for (int i = 0; i < BEATS; i++) d[i] = $urandom;
    write_burst(addr, d, 0);
    for (int i = 0; i < BEATS; i++) d[i] = $urandom;
    do_req(1'b1, addr, 1'b0, acc);
    while (b < 7 && n < 100) begin
      wdata       = d[b];
      wdata_valid = 1'b1;
      hs = (wdata_ready === 1'b1);
      @(negedge clk);
      n++;
      if (hs) begin
        mem_m[widx(addr, b)] = d[b];
        b++;
      end
    end
    wdata = d[7];
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, wdata_ready, rdata_valid, rdata_last, wr_done, busy, err} !== 7'b1000000 || rdata !== 32'h0 || b != 7) begin
      errors++;
      $display("FAIL reset_mid_write: rdy/wrdy/rv/last/done/busy/err=%b rdata=%h beats=%0d required 1000000 0 7",
               {req_ready, wdata_ready, rdata_valid, rdata_last, wr_done, busy, err}, rdata, b);
    end
    wdata_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (wr_done !== 1'b0) wd++;
    end
    checks++;
    if (wd != 0) begin
      errors++;
      $display("FAIL no_wr_done_after_abort: wr_done high %0d cycles, required 0", wd);
    end
    read_burst(addr, 0);
  endtask

  task automatic test_range();
    logic [31:0] d [BEATS];
    for (int i = 0; i < BEATS; i++) d[i] = $urandom;
    write_burst(32'h0000_0000, d, 20);
    for (int i = 0; i < BEATS; i++) d[i] = $urandom;
    write_burst(32'h0000_0040, d, 0);
    read_burst(32'h0010_0000, 2);
    for (int i = 0; i < BEATS; i++) d[i] = $urandom;
    write_burst(32'h0010_0040, d, 10);
    read_burst(32'h0000_0040, 0);
    read_burst(32'h0000_0000, 2);
  endtask

  task automatic test_random();
    logic [31:0] d [BEATS];
    logic [31:0] addr;
    bit written [8];
    int k;
    for (int i = 0; i < 8; i++) written[i] = 1'b0;
    for (int it = 0; it < 8; it++) begin
      k = int'($urandom_range(7));
      addr = 32'h0000_1000 + 32'(k * 64) + 32'($urandom_range(63));
      for (int i = 0; i < BEATS; i++) d[i] = $urandom;
      write_burst(addr, d, int'($urandom_range(50)));
      written[k] = 1'b1;
      k = int'($urandom_range(7));
      while (!written[k]) k = (k + 1) % 8;
      addr = 32'h0000_1000 + 32'(k * 64) + 32'($urandom_range(63));
      read_burst(addr, 2);
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem_m[i] = '0;
    test_reset();
    test_fill_latency();
    test_write_then_read();
    test_read_stall();
    test_back_to_back();
    test_reset_mid_write();
    test_range();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
